// File: rtl/nv_nvdla_csb_arb.sv
// Two-master CSB request arbiter with registered output stage and in-order response tag FIFO.
// Build option: define NVDLA_CSB_ARB_FIXED_PRIO_EN for fixed m0 priority instead of round-robin.
module nv_nvdla_csb_arb #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic        m0_req_pvld,
  output logic        m0_req_prdy,
  input  logic [62:0] m0_req_pd,
  input  logic        m1_req_pvld,
  output logic        m1_req_prdy,
  input  logic [62:0] m1_req_pd,
  output logic        s_req_pvld,
  input  logic        s_req_prdy,
  output logic [62:0] s_req_pd,
  input  logic        s_resp_valid,
  input  logic [33:0] s_resp_pd,
  output logic        m0_resp_valid,
  output logic [33:0] m0_resp_pd,
  output logic        m1_resp_valid,
  output logic [33:0] m1_resp_pd,
  output logic        rsp_orphan
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic          r_s_req_pvld;
  logic [62:0]   r_s_req_pd;
  logic          r_tag_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_m0_resp_valid;
  logic          r_m1_resp_valid;
  logic [33:0]   r_m0_resp_pd;
  logic [33:0]   r_m1_resp_pd;
  logic          r_rsp_orphan;

  logic [1:0]    w_pvld;
  logic [1:0]    w_rb;
  logic [1:0]    w_cand;
  logic [1:0]    w_grant;
  logic [62:0]   w_pd [2];
  logic [62:0]   w_grant_pd;
  logic          w_load;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_push_tag;
  logic          w_pop;
  logic          w_head_tag;

  assign w_pvld  = {m1_req_pvld, m0_req_pvld};
  assign w_pd[0] = m0_req_pd;
  assign w_pd[1] = m1_req_pd;

  // Grants are suppressed while reset is held so no master sees a spurious accept.
  assign w_load  = !nvdla_core_rst && (!r_s_req_pvld || s_req_prdy);
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cand
      // Reads and non-posted writes need a tag slot; posted writes never do.
      assign w_rb[gi]   = !w_pd[gi][54] || w_pd[gi][55];
      assign w_cand[gi] = w_load && w_pvld[gi] && !(w_rb[gi] && w_full);
    end
  endgenerate

`ifdef NVDLA_CSB_ARB_FIXED_PRIO_EN
  assign w_grant[0] = w_cand[0];
  assign w_grant[1] = w_cand[1] && !w_cand[0];
`else
  logic r_rr_ptr;

  assign w_grant[0] = w_cand[0] && (!w_cand[1] || !r_rr_ptr);
  assign w_grant[1] = w_cand[1] && (!w_cand[0] || r_rr_ptr);

  // Pointer moves to the master that lost (or was idle) on each grant.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_rr_ptr <= 1'b0;
    end else if (|w_grant) begin
      r_rr_ptr <= w_grant[0];
    end
  end
`endif

  assign m0_req_prdy = w_grant[0];
  assign m1_req_prdy = w_grant[1];
  assign w_grant_pd  = w_grant[1] ? m1_req_pd : m0_req_pd;
  assign w_push      = |(w_grant & w_rb);
  assign w_push_tag  = w_grant[1];
  assign w_pop       = s_resp_valid && !w_empty;
  assign w_head_tag  = r_tag_mem[r_rd_ptr];

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_s_req_pvld <= 1'b0;
      r_s_req_pd   <= '0;
    end else if (|w_grant) begin
      r_s_req_pvld <= 1'b1;
      r_s_req_pd   <= w_grant_pd;
    end else if (s_req_prdy) begin
      r_s_req_pvld <= 1'b0;
    end
  end

  // Tag storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge nvdla_core_clk) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr] <= w_push_tag;
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_m0_resp_valid <= 1'b0;
      r_m1_resp_valid <= 1'b0;
      r_m0_resp_pd    <= '0;
      r_m1_resp_pd    <= '0;
      r_rsp_orphan    <= 1'b0;
    end else begin
      r_m0_resp_valid <= w_pop && !w_head_tag;
      r_m1_resp_valid <= w_pop && w_head_tag;
      r_rsp_orphan    <= s_resp_valid && w_empty;
      if (w_pop && !w_head_tag) begin
        r_m0_resp_pd <= s_resp_pd;
      end
      if (w_pop && w_head_tag) begin
        r_m1_resp_pd <= s_resp_pd;
      end
    end
  end

  assign s_req_pvld    = r_s_req_pvld;
  assign s_req_pd      = r_s_req_pd;
  assign m0_resp_valid = r_m0_resp_valid;
  assign m1_resp_valid = r_m1_resp_valid;
  assign m0_resp_pd    = r_m0_resp_pd;
  assign m1_resp_pd    = r_m1_resp_pd;
  assign rsp_orphan    = r_rsp_orphan;

endmodule

// File: tb/tb_nv_nvdla_csb_arb.sv
// Scoreboard bench for nv_nvdla_csb_arb: expected downstream requests and master responses are queued as driven.
module tb_nv_nvdla_csb_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req_pvld, m1_req_pvld;
  logic        m0_req_prdy, m1_req_prdy;
  logic [62:0] m0_req_pd, m1_req_pd;
  logic        s_req_pvld, s_req_prdy;
  logic [62:0] s_req_pd;
  logic        s_resp_valid;
  logic [33:0] s_resp_pd;
  logic        m0_resp_valid, m1_resp_valid;
  logic [33:0] m0_resp_pd, m1_resp_pd;
  logic        rsp_orphan;

  typedef struct packed {
    logic [2:0]  who;   // {orphan, m1, m0}
    logic [33:0] pd;
  } rsp_t;

  logic [62:0] exp_req [$];
  rsp_t        exp_rsp [$];
  int          n_checks = 0;
  int          n_errors = 0;

  nv_nvdla_csb_arb #(.FIFO_DEPTH(4)) dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rst(rst),
    .m0_req_pvld(m0_req_pvld),
    .m0_req_prdy(m0_req_prdy),
    .m0_req_pd(m0_req_pd),
    .m1_req_pvld(m1_req_pvld),
    .m1_req_prdy(m1_req_prdy),
    .m1_req_pd(m1_req_pd),
    .s_req_pvld(s_req_pvld),
    .s_req_prdy(s_req_prdy),
    .s_req_pd(s_req_pd),
    .s_resp_valid(s_resp_valid),
    .s_resp_pd(s_resp_pd),
    .m0_resp_valid(m0_resp_valid),
    .m0_resp_pd(m0_resp_pd),
    .m1_resp_valid(m1_resp_valid),
    .m1_resp_pd(m1_resp_pd),
    .rsp_orphan(rsp_orphan)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [62:0] mk_pd(input logic wr, input logic np,
                                        input logic [31:0] wdat, input logic [21:0] addr);
    return {2'b00, 4'hF, 1'b0, np, wr, wdat, addr};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rsp(input logic [2:0] who, input logic [33:0] pd);
    rsp_t e;
    e.who = who;
    e.pd  = pd;
    exp_rsp.push_back(e);
  endtask

  // Downstream transfers and master responses are consumed from the scoreboard away from the active edge.
  always @(negedge clk) begin
    rsp_t        e;
    logic [33:0] got_pd;
    if (s_req_pvld && s_req_prdy) begin
      if (exp_req.size() == 0) check("s_req_unexpected", 64'(1), 64'(0));
      else check("s_req_pd", 64'(s_req_pd), 64'(exp_req.pop_front()));
    end
    if (m0_resp_valid || m1_resp_valid || rsp_orphan) begin
      got_pd = m1_resp_valid ? m1_resp_pd : (m0_resp_valid ? m0_resp_pd : 34'h0);
      if (exp_rsp.size() == 0) begin
        check("rsp_unexpected", 64'(1), 64'(0));
      end else begin
        e = exp_rsp.pop_front();
        check("rsp_who", 64'({rsp_orphan, m1_resp_valid, m0_resp_valid}), 64'(e.who));
        check("rsp_pd", 64'(got_pd), 64'(e.pd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          win [4];
    int          w3;
    logic [62:0] pd0, pd1;

    m0_req_pvld = 0; m1_req_pvld = 0; m0_req_pd = '0; m1_req_pd = '0;
    s_req_prdy = 0; s_resp_valid = 0; s_resp_pd = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_s_req_pvld", 64'(s_req_pvld), 64'(0));
    check("rst_s_req_pd", 64'(s_req_pd), 64'(0));
    check("rst_prdy", 64'({m1_req_prdy, m0_req_prdy}), 64'(0));
    check("rst_resp_valid", 64'({m1_resp_valid, m0_resp_valid}), 64'(0));
    check("rst_resp_pd", 64'(m0_resp_pd | m1_resp_pd), 64'(0));
    check("rst_orphan", 64'(rsp_orphan), 64'(0));
    rst = 0;

    // Both masters hold reads: round-robin alternates starting with m0.
    s_req_prdy = 1;
    for (int k = 0; k < 4; k++) begin
`ifdef NVDLA_CSB_ARB_FIXED_PRIO_EN
      win[k] = 0;
`else
      win[k] = k % 2;
`endif
      m0_req_pvld = 1; m1_req_pvld = 1;
      m0_req_pd = mk_pd(1'b0, 1'b0, 32'h0, 22'h100 + 22'(k));
      m1_req_pd = mk_pd(1'b0, 1'b0, 32'h0, 22'h200 + 22'(k));
      #1;
      check("rr_grant", 64'({m1_req_prdy, m0_req_prdy}), 64'(win[k] == 1 ? 2 : 1));
      exp_req.push_back(win[k] == 1 ? m1_req_pd : m0_req_pd);
      step();
    end
    m0_req_pvld = 0; m1_req_pvld = 0;
    for (int k = 0; k < 4; k++) begin
      s_resp_valid = 1; s_resp_pd = 34'h0_0000_1000 + 34'(k);
      push_rsp(win[k] == 1 ? 3'b010 : 3'b001, s_resp_pd);
      step();
      check("rr_resp_lat", 64'({m1_resp_valid, m0_resp_valid}), 64'(win[k] == 1 ? 2 : 1));
    end
    s_resp_valid = 0;

    // Four outstanding reads fill the tag FIFO; posted write still passes.
    for (int k = 0; k < 4; k++) begin
      m0_req_pvld = 1; m0_req_pd = mk_pd(1'b0, 1'b0, 32'h0, 22'h300 + 22'(k));
      #1;
      check("full_fill_prdy", 64'(m0_req_prdy), 64'(1));
      exp_req.push_back(m0_req_pd);
      step();
    end
    m0_req_pd = mk_pd(1'b0, 1'b0, 32'h0, 22'h304);
    m1_req_pvld = 1; m1_req_pd = mk_pd(1'b1, 1'b0, 32'hCAFE_F00D, 22'h3F0);
    #1;
    check("full_prdy", 64'({m1_req_prdy, m0_req_prdy}), 64'(2));
    exp_req.push_back(m1_req_pd);
    step();
    m1_req_pvld = 0;
    #1;
    check("full_m0_stall", 64'(m0_req_prdy), 64'(0));
    step();
    s_resp_valid = 1; s_resp_pd = 34'h0_1111_0000;
    #1;
    check("full_pop_same_cycle", 64'(m0_req_prdy), 64'(0));
    push_rsp(3'b001, s_resp_pd);
    step();
    s_resp_valid = 0;
    #1;
    check("full_unstall", 64'(m0_req_prdy), 64'(1));
    exp_req.push_back(m0_req_pd);
    step();
    m0_req_pvld = 0;
    for (int k = 0; k < 4; k++) begin
      s_resp_valid = 1; s_resp_pd = 34'h0_2222_0000 + 34'(k);
      push_rsp(3'b001, s_resp_pd);
      step();
    end
    s_resp_valid = 0;

    // Downstream backpressure holds the output register and blocks grants.
    s_req_prdy = 0;
    m0_req_pvld = 1; m0_req_pd = 63'h123_4567_8ABC;
    #1;
    check("bp_first_grant", 64'(m0_req_prdy), 64'(1));
    exp_req.push_back(m0_req_pd);
    step();
    pd0 = mk_pd(1'b1, 1'b0, 32'hAAAA_0000, 22'h010);
    pd1 = mk_pd(1'b1, 1'b0, 32'hBBBB_0000, 22'h020);
    m0_req_pd = pd0; m1_req_pvld = 1; m1_req_pd = pd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_pvld", 64'(s_req_pvld), 64'(1));
      check("bp_pd_stable", 64'(s_req_pd), 64'h123_4567_8ABC);
      check("bp_no_grant", 64'({m1_req_prdy, m0_req_prdy}), 64'(0));
      step();
    end
    s_req_prdy = 1;
`ifdef NVDLA_CSB_ARB_FIXED_PRIO_EN
    w3 = 0;
`else
    w3 = 1;
`endif
    #1;
    check("bp_release_grant", 64'({m1_req_prdy, m0_req_prdy}), 64'(w3 == 1 ? 2 : 1));
    exp_req.push_back(w3 == 1 ? pd1 : pd0);
    step();
    m0_req_pvld = 0; m1_req_pvld = 0;
    s_resp_valid = 1; s_resp_pd = 34'h1_0000_0005;
    push_rsp(3'b001, s_resp_pd);
    step();
    s_resp_valid = 0;

    // Non-posted write from m1 gets its ack.
    m1_req_pvld = 1; m1_req_pd = mk_pd(1'b1, 1'b1, 32'h5555_AAAA, 22'h040);
    #1;
    check("np_grant", 64'(m1_req_prdy), 64'(1));
    exp_req.push_back(m1_req_pd);
    step();
    m1_req_pvld = 0;
    step();
    s_resp_valid = 1; s_resp_pd = 34'h2_0000_0000;
    push_rsp(3'b010, s_resp_pd);
    step();
    s_resp_valid = 0;
    check("np_resp_valid", 64'({m1_resp_valid, m0_resp_valid}), 64'(2));
    step();
    check("np_resp_hold", 64'({m1_resp_valid, m1_resp_pd}), 64'h2_0000_0000);

    // Response with nothing outstanding.
    s_resp_valid = 1; s_resp_pd = 34'h0_DEAD_BEEF;
    push_rsp(3'b100, 34'h0);
    step();
    s_resp_valid = 0;
    check("orphan_pulse", 64'({rsp_orphan, m1_resp_valid, m0_resp_valid}), 64'(4));
    step();
    check("orphan_clear", 64'(rsp_orphan), 64'(0));

    // Reset with two tags outstanding, one request still in the output register.
    m0_req_pvld = 1; m0_req_pd = mk_pd(1'b0, 1'b0, 32'h0, 22'h050);
    #1;
    check("rst_t_m0_grant", 64'(m0_req_prdy), 64'(1));
    exp_req.push_back(m0_req_pd);
    step();
    m0_req_pvld = 0;
    m1_req_pvld = 1; m1_req_pd = mk_pd(1'b0, 1'b0, 32'h0, 22'h060);
    #1;
    check("rst_t_m1_grant", 64'(m1_req_prdy), 64'(1));
    exp_req.push_back(m1_req_pd);
    step();
    m1_req_pvld = 0; s_req_prdy = 0;
    #1;
    rst = 1;
    #1;
    void'(exp_req.pop_back());
    check("mid_rst_s_req_pvld", 64'(s_req_pvld), 64'(0));
    check("mid_rst_s_req_pd", 64'(s_req_pd), 64'(0));
    check("mid_rst_resp_pd", 64'(m0_resp_pd | m1_resp_pd), 64'(0));
    check("mid_rst_resp_valid", 64'({rsp_orphan, m1_resp_valid, m0_resp_valid}), 64'(0));
    step();
    step();
    rst = 0; s_req_prdy = 1;
    s_resp_valid = 1; s_resp_pd = 34'h0_0BAD_0BAD;
    push_rsp(3'b100, 34'h0);
    step();
    s_resp_valid = 0;
    check("post_rst_orphan", 64'({rsp_orphan, m1_resp_valid, m0_resp_valid}), 64'(4));
    m0_req_pvld = 1; m0_req_pd = mk_pd(1'b0, 1'b0, 32'h0, 22'h070);
    #1;
    check("post_rst_grant", 64'(m0_req_prdy), 64'(1));
    exp_req.push_back(m0_req_pd);
    step();
    m0_req_pvld = 0;
    step();
    s_resp_valid = 1; s_resp_pd = 34'h0_7777_7777;
    push_rsp(3'b001, s_resp_pd);
    step();
    s_resp_valid = 0;
    check("post_rst_route", 64'({rsp_orphan, m1_resp_valid, m0_resp_valid}), 64'(1));
    step();
    step();

    check("req_queue_drained", 64'(exp_req.size()), 64'(0));
    check("rsp_queue_drained", 64'(exp_rsp.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
